// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 read-side engine: op codes, phase encoding,
// command constants and default 50 MHz bus timing.
package lcd_pkg;

   localparam logic [1:0] OP_STATUS = 2'b00;
   localparam logic [1:0] OP_DATA   = 2'b01;
   localparam logic [1:0] OP_POLL   = 2'b10;

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_SETUP = 3'd1,
      PH_EHIGH = 3'd2,
      PH_HOLD  = 3'd3,
      PH_GAP   = 3'd4
   } phase_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } top_state_t;

   // HD44780 command bytes used by the companion writer
   localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
   localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_LINE1        = 8'h80;
   localparam logic [7:0] CMD_LINE2        = 8'hC0;

   localparam int unsigned DEF_T_SETUP   = 4;
   localparam int unsigned DEF_T_EHIGH   = 25;
   localparam int unsigned DEF_T_HOLD    = 4;
   localparam int unsigned DEF_T_GAP     = 25;
   localparam int unsigned DEF_MAX_POLLS = 4096;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_read_cycle.sv
// One HD44780 RW=1 bus cycle: SETUP, E_HIGH, HOLD, GAP. Bus controls are registered
// alongside the phase so they change together; start in the last GAP cycle chains a new read.
module lcd_read_cycle
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_EHIGH = DEF_T_EHIGH,
   parameter int unsigned T_HOLD  = DEF_T_HOLD,
   parameter int unsigned T_GAP   = DEF_T_GAP
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs_sel,
   input  logic [7:0] lcd_data_in,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] sample,
   output logic       hold_done_c,
   output logic       gap_done_c
);

   localparam int unsigned T_MAX = max4(T_SETUP, T_EHIGH, T_HOLD, T_GAP);
   localparam int unsigned CW    = $clog2(T_MAX + 1);

   phase_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          rs_next, rw_next, e_next;
   logic          sample_en_c;

   // Phase sequencing; cnt restarts at 0 on every phase entry
   always_comb begin
      state_next  = state;
      cnt_next    = cnt + CW'(1);
      sample_en_c = 1'b0;
      hold_done_c = 1'b0;
      gap_done_c  = 1'b0;
      case (state)
         PH_IDLE: begin
            cnt_next = '0;
            if (start) state_next = PH_SETUP;
         end
         PH_SETUP: begin
            if (cnt == CW'(T_SETUP - 1)) begin
               state_next = PH_EHIGH;
               cnt_next   = '0;
            end
         end
         PH_EHIGH: begin
            if (cnt == CW'(T_EHIGH - 1)) begin
               state_next  = PH_HOLD;
               cnt_next    = '0;
               sample_en_c = 1'b1;
            end
         end
         PH_HOLD: begin
            if (cnt == CW'(T_HOLD - 1)) begin
               state_next  = PH_GAP;
               cnt_next    = '0;
               hold_done_c = 1'b1;
            end
         end
         PH_GAP: begin
            if (cnt == CW'(T_GAP - 1)) begin
               gap_done_c = 1'b1;
               cnt_next   = '0;
               state_next = start ? PH_SETUP : PH_IDLE;
            end
         end
         default: begin
            state_next = PH_IDLE;
            cnt_next   = '0;
         end
      endcase

      // RS is captured only when a cycle begins, so it is frozen for the whole E pulse
      e_next  = (state_next == PH_EHIGH);
      rw_next = (state_next == PH_SETUP) || (state_next == PH_EHIGH) || (state_next == PH_HOLD);
      rs_next = lcd_rs;
      if (!rw_next)
         rs_next = 1'b0;
      else if ((state == PH_IDLE) || (state == PH_GAP))
         rs_next = rs_sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= PH_IDLE;
         cnt    <= '0;
         lcd_rs <= 1'b0;
         lcd_rw <= 1'b0;
         lcd_e  <= 1'b0;
         sample <= '0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         lcd_rs <= rs_next;
         lcd_rw <= rw_next;
         lcd_e  <= e_next;
         if (sample_en_c) sample <= lcd_data_in;
      end
   end

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read engine: request handshake around lcd_read_cycle, returning BF/AC or a RAM
// byte, with an optional busy-flag poll bounded by MAX_POLLS reads.
module lcd_status_reader
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP   = DEF_T_SETUP,
   parameter int unsigned T_EHIGH   = DEF_T_EHIGH,
   parameter int unsigned T_HOLD    = DEF_T_HOLD,
   parameter int unsigned T_GAP     = DEF_T_GAP,
   parameter int unsigned MAX_POLLS = DEF_MAX_POLLS
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   output logic       req_ready,
   output logic       resp_valid,
   output logic [7:0] resp_data,
   output logic       resp_busy,
   output logic [6:0] resp_addr,
   output logic       resp_timeout,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   input  logic [7:0] lcd_data_in
);

   localparam int unsigned PW = $clog2(MAX_POLLS + 1);

   top_state_t    state, state_next;
   logic [1:0]    op, op_next;
   logic [PW-1:0] poll_cnt, poll_cnt_next;
   logic          retry, retry_next;
   logic          req_ready_next, resp_valid_next;
   logic [7:0]    resp_data_next;
   logic          resp_busy_next, resp_timeout_next;
   logic [6:0]    resp_addr_next;

   logic [1:0]    op_in_c;
   logic          accept_c, start_c, rs_sel_c, more_c;
   logic          hold_done_c, gap_done_c;
   logic [7:0]    sample;

   lcd_read_cycle #(
      .T_SETUP (T_SETUP),
      .T_EHIGH (T_EHIGH),
      .T_HOLD  (T_HOLD),
      .T_GAP   (T_GAP)
   ) u_cycle (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_c),
      .rs_sel      (rs_sel_c),
      .lcd_data_in (lcd_data_in),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e),
      .sample      (sample),
      .hold_done_c (hold_done_c),
      .gap_done_c  (gap_done_c)
   );

   // Request handshake, poll retry decision and response capture
   always_comb begin
      state_next        = state;
      op_next           = op;
      poll_cnt_next     = poll_cnt;
      retry_next        = retry;
      resp_valid_next   = 1'b0;
      resp_data_next    = resp_data;
      resp_busy_next    = resp_busy;
      resp_addr_next    = resp_addr;
      resp_timeout_next = resp_timeout;

      // Reserved op code 11 behaves as a status read
      op_in_c  = ((req_op == OP_DATA) || (req_op == OP_POLL)) ? req_op : OP_STATUS;
      accept_c = req_valid && req_ready && (state == ST_IDLE);
      start_c  = accept_c || (gap_done_c && retry);
      rs_sel_c = accept_c ? (op_in_c == OP_DATA) : (op == OP_DATA);
      more_c   = (op == OP_POLL) && sample[7] && (poll_cnt < PW'(MAX_POLLS - 1));

      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_next    = ST_BUSY;
               op_next       = op_in_c;
               poll_cnt_next = '0;
               retry_next    = 1'b0;
            end
         end
         ST_BUSY: begin
            if (hold_done_c) begin
               if (more_c) begin
                  retry_next    = 1'b1;
                  poll_cnt_next = poll_cnt + PW'(1);
               end else begin
                  resp_valid_next = 1'b1;
                  resp_data_next  = sample;
                  if (op == OP_DATA) begin
                     resp_busy_next    = 1'b0;
                     resp_addr_next    = '0;
                     resp_timeout_next = 1'b0;
                  end else begin
                     resp_busy_next    = sample[7];
                     resp_addr_next    = sample[6:0];
                     resp_timeout_next = (op == OP_POLL) && sample[7];
                  end
               end
            end
            if (gap_done_c) begin
               retry_next = 1'b0;
               if (!retry) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Ready reasserts one cycle after returning to idle
      req_ready_next = (state == ST_IDLE) && !accept_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op           <= OP_STATUS;
         poll_cnt     <= '0;
         retry        <= 1'b0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         resp_busy    <= 1'b0;
         resp_addr    <= '0;
         resp_timeout <= 1'b0;
      end else begin
         state        <= state_next;
         op           <= op_next;
         poll_cnt     <= poll_cnt_next;
         retry        <= retry_next;
         req_ready    <= req_ready_next;
         resp_valid   <= resp_valid_next;
         resp_data    <= resp_data_next;
         resp_busy    <= resp_busy_next;
         resp_addr    <= resp_addr_next;
         resp_timeout <= resp_timeout_next;
      end
   end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader with a simple HD44780 read-side bus model.
module tb_lcd_status_reader;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_op = 2'b00;
   logic       req_ready, resp_valid, resp_busy, resp_timeout;
   logic [7:0] resp_data;
   logic [6:0] resp_addr;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data_in;

   int errors = 0;
   int checks = 0;

   int         mode = 0;
   logic [7:0] fixed_byte = 8'h00;
   int         e_pulses = 0;
   int         poll_base = 0;
   logic       e_prev_cnt = 1'b0;

   int   rw_viol = 0;
   int   rs_viol = 0;
   logic e_prev_m = 1'b0;
   logic rs_hold = 1'b0;

   always #5 clk = ~clk;

   lcd_status_reader #(.MAX_POLLS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_busy    (resp_busy),
      .resp_addr    (resp_addr),
      .resp_timeout (resp_timeout),
      .lcd_rs       (lcd_rs),
      .lcd_rw       (lcd_rw),
      .lcd_e        (lcd_e),
      .lcd_data_in  (lcd_data_in)
   );

   // LCD drives the bus only while E is high; mode 1 reports busy for three reads, then 0x05
   always_comb begin
      if (lcd_e !== 1'b1)
         lcd_data_in = 8'hFF;
      else if (mode == 1)
         lcd_data_in = ((e_pulses - poll_base) < 3) ? 8'h85 : 8'h05;
      else
         lcd_data_in = fixed_byte;
   end

   always @(posedge clk) begin
      if (e_prev_cnt === 1'b1 && lcd_e === 1'b0) e_pulses <= e_pulses + 1;
      e_prev_cnt <= lcd_e;
   end

   // Bus protocol watch: E only with RW=1, RS frozen through each E pulse
   always @(negedge clk) begin
      if (lcd_e === 1'b1) begin
         if (lcd_rw !== 1'b1) rw_viol++;
         if (e_prev_m === 1'b1 && lcd_rs !== rs_hold) rs_viol++;
         rs_hold = lcd_rs;
      end
      e_prev_m = lcd_e;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the accept cycle; trace runs until req_ready returns (bounded)
   task automatic do_read(input logic [1:0] op, input bit keep,
                          output int e_first, output int e_last, output int e_rises,
                          output int rv_cycle, output int rv_cnt, output int rdy_cycle,
                          output logic rs_e);
      int   wait_n;
      logic e_q;
      wait_n = 0;
      while (req_ready !== 1'b1 && wait_n < 200) begin
         tick();
         wait_n++;
      end
      if (req_ready !== 1'b1) chk("ready_wait", 32'(req_ready), 32'd1);
      req_op    = op;
      req_valid = 1'b1;
      e_first = -1; e_last = -1; e_rises = 0;
      rv_cycle = -1; rv_cnt = 0; rdy_cycle = -1;
      rs_e = 1'b0; e_q = 1'b0;
      for (int c = 1; c <= 1500 && rdy_cycle < 0; c++) begin
         tick();
         if (!keep) req_valid = 1'b0;
         if (lcd_e === 1'b1) begin
            if (e_first < 0) e_first = c;
            e_last = c;
            rs_e   = lcd_rs;
            if (e_q !== 1'b1) e_rises++;
         end
         e_q = lcd_e;
         if (resp_valid === 1'b1) begin
            rv_cnt++;
            if (rv_cycle < 0) rv_cycle = c;
         end
         if (req_ready === 1'b1) rdy_cycle = c;
      end
   endtask

   initial begin
      int   ef, el, er, rvc, rvn, rdy;
      logic rse;
      int   rv_seen;

      // Power-on reset
      rst_n = 1'b0;
      repeat (5) tick();
      chk("reset_outputs", 32'({req_ready, resp_valid, resp_data, resp_busy, resp_addr,
                                resp_timeout, lcd_rs, lcd_rw, lcd_e}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      // OP_STATUS, LCD returns 0x47
      mode = 0; fixed_byte = 8'h47;
      do_read(OP_STATUS, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("st_e_first", 32'(ef), 32'd5);
      chk("st_e_last", 32'(el), 32'd29);
      chk("st_e_rises", 32'(er), 32'd1);
      chk("st_rs", 32'(rse), 32'd0);
      chk("st_rv_cycle", 32'(rvc), 32'd34);
      chk("st_rv_cnt", 32'(rvn), 32'd1);
      chk("st_ready_cycle", 32'(rdy), 32'd60);
      chk("st_data", 32'(resp_data), 32'h47);
      chk("st_busy", 32'(resp_busy), 32'd0);
      chk("st_addr", 32'(resp_addr), 32'h47);
      chk("st_timeout", 32'(resp_timeout), 32'd0);
      chk("st_idle_bus", 32'({lcd_rs, lcd_rw, lcd_e}), 32'd0);

      // OP_DATA, LCD returns 0xA5
      fixed_byte = 8'hA5;
      do_read(OP_DATA, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("dt_rs", 32'(rse), 32'd1);
      chk("dt_rv_cycle", 32'(rvc), 32'd34);
      chk("dt_ready_cycle", 32'(rdy), 32'd60);
      chk("dt_data", 32'(resp_data), 32'hA5);
      chk("dt_busy", 32'(resp_busy), 32'd0);
      chk("dt_addr", 32'(resp_addr), 32'd0);

      // OP_POLL, three busy reads then 0x05
      mode = 1; poll_base = e_pulses;
      do_read(OP_POLL, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("pl_e_rises", 32'(er), 32'd4);
      chk("pl_e_last", 32'(el), 32'd203);
      chk("pl_rv_cnt", 32'(rvn), 32'd1);
      chk("pl_rv_cycle", 32'(rvc), 32'd208);
      chk("pl_ready_cycle", 32'(rdy), 32'd234);
      chk("pl_data", 32'(resp_data), 32'h05);
      chk("pl_busy", 32'(resp_busy), 32'd0);
      chk("pl_addr", 32'(resp_addr), 32'h05);
      chk("pl_timeout", 32'(resp_timeout), 32'd0);

      // OP_POLL with BF stuck high, MAX_POLLS=8
      mode = 0; fixed_byte = 8'h92;
      do_read(OP_POLL, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("to_e_rises", 32'(er), 32'd8);
      chk("to_rv_cnt", 32'(rvn), 32'd1);
      chk("to_rv_cycle", 32'(rvc), 32'd440);
      chk("to_ready_cycle", 32'(rdy), 32'd466);
      chk("to_busy", 32'(resp_busy), 32'd1);
      chk("to_addr", 32'(resp_addr), 32'h12);
      chk("to_timeout", 32'(resp_timeout), 32'd1);

      // Reserved op 11 acts as status read and clears timeout
      fixed_byte = 8'hC3;
      do_read(2'b11, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("rsv_rs", 32'(rse), 32'd0);
      chk("rsv_data", 32'(resp_data), 32'hC3);
      chk("rsv_busy", 32'(resp_busy), 32'd1);
      chk("rsv_addr", 32'(resp_addr), 32'h43);
      chk("rsv_timeout", 32'(resp_timeout), 32'd0);

      // Back-to-back: req_valid held high across the first read
      fixed_byte = 8'h47;
      do_read(OP_STATUS, 1'b1, ef, el, er, rvc, rvn, rdy, rse);
      chk("b2b_first_e_rises", 32'(er), 32'd1);
      chk("b2b_first_rv_cnt", 32'(rvn), 32'd1);
      chk("b2b_first_ready", 32'(rdy), 32'd60);
      do_read(OP_STATUS, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("b2b_second_e_first", 32'(ef), 32'd5);
      chk("b2b_second_rv_cycle", 32'(rvc), 32'd34);
      chk("b2b_second_addr", 32'(resp_addr), 32'h47);

      // Reset in the middle of an E pulse
      req_op = OP_STATUS; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (9) tick();
      chk("mid_e_high", 32'(lcd_e), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_bus", 32'({lcd_rw, lcd_e}), 32'd0);
      rv_seen = 0;
      repeat (4) begin
         tick();
         if (resp_valid === 1'b1) rv_seen++;
      end
      chk("mid_rst_no_resp", 32'(rv_seen), 32'd0);
      chk("mid_rst_outputs", 32'({req_ready, resp_valid, resp_data, resp_busy, resp_addr,
                                  resp_timeout, lcd_rs, lcd_rw, lcd_e}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      fixed_byte = 8'h2A;
      do_read(OP_STATUS, 1'b0, ef, el, er, rvc, rvn, rdy, rse);
      chk("post_rst_rv_cycle", 32'(rvc), 32'd34);
      chk("post_rst_addr", 32'(resp_addr), 32'h2A);

      chk("no_e_with_rw0", 32'(rw_viol), 32'd0);
      chk("rs_stable_in_e", 32'(rs_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
